// File: rtl/id_hazard_controller.sv
// id_hazard_controller: decode-side sequencing control for the five-stage core.
// Tracks the EX/MEM/WB destinations in a shadow scoreboard. From that scoreboard
// and the current ID instruction it derives the freeze, flush and bubble
// controls for the pipeline registers.
module id_hazard_controller #(
  parameter bit FORWARD_EN = 1'b0,
  parameter bit WB_HAZARD  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_src1,
  input  logic [4:0]  id_src2,
  input  logic        id_uses_src2,
  input  logic        id_wb_en,
  input  logic [4:0]  id_dest,
  input  logic        id_mem_read,
  input  logic        br_taken,
  input  logic        mem_busy,
  output logic        if_freeze,
  output logic        id_freeze,
  output logic        ex_bubble,
  output logic        if_flush,
  output logic        late_freeze,
  output logic [15:0] stall_cnt
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic             valid;
    logic             wb;
    logic [REG_W-1:0] dest;
    logic             mem_read;
  } sb_entry_t;

  // Per-cycle action after applying the priority mem_busy > branch > hazard.
  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_STALL = 2'd1,
    MODE_FLUSH = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  sb_entry_t ex_q, ex_d;
  sb_entry_t mem_q, mem_d;
  sb_entry_t wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic  ex_match, mem_match, wb_match;
  logic  hazard;
  mode_e mode;

  logic if_freeze_c, ex_bubble_c, if_flush_c, late_freeze_c;

  // True when an entry will write a nonzero register that the ID instruction reads.
  function automatic logic entry_match(input sb_entry_t  e,
                                       input logic [4:0] src1,
                                       input logic [4:0] src2,
                                       input logic       uses_src2);
    logic hit;
    hit = (e.dest == src1) || (uses_src2 && (e.dest == src2));
    return e.valid && e.wb && (e.dest != REG_W'(0)) && hit;
  endfunction

  // RAW detection against the scoreboard and selection of this cycle's action.
  always_comb begin
    mode      = MODE_RUN;
    ex_match  = entry_match(ex_q,  id_src1, id_src2, id_uses_src2);
    mem_match = entry_match(mem_q, id_src1, id_src2, id_uses_src2);
    wb_match  = entry_match(wb_q,  id_src1, id_src2, id_uses_src2);
    if (FORWARD_EN) begin
      // With forwarding only a load in EX cannot supply its result in time.
      hazard = id_valid && ex_match && ex_q.mem_read;
    end else begin
      hazard = id_valid && (ex_match || mem_match || (WB_HAZARD && wb_match));
    end
    if (mem_busy) begin
      mode = MODE_HOLD;
    end else if (br_taken) begin
      mode = MODE_FLUSH;
    end else if (hazard) begin
      mode = MODE_STALL;
    end
  end

  // Pipeline control outputs. They are held low while reset is asserted.
  always_comb begin
    if_freeze_c   = 1'b0;
    ex_bubble_c   = 1'b0;
    if_flush_c    = 1'b0;
    late_freeze_c = 1'b0;
    if (rst) begin
      unique case (mode)
        MODE_HOLD: begin
          if_freeze_c   = 1'b1;
          late_freeze_c = 1'b1;
        end
        MODE_FLUSH: begin
          if_flush_c  = 1'b1;
          ex_bubble_c = 1'b1;
        end
        MODE_STALL: begin
          if_freeze_c = 1'b1;
          ex_bubble_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Scoreboard shift and stall counter next state.
  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q;
    if (mode != MODE_HOLD) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (mode == MODE_RUN) begin
        ex_d = '{valid: id_valid, wb: id_wb_en, dest: id_dest, mem_read: id_mem_read};
      end else begin
        // A bubble (stall) or a squashed instruction (flush) is never tracked.
        ex_d = '0;
      end
    end
    if ((mode == MODE_STALL) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign if_freeze   = if_freeze_c;
  assign id_freeze   = if_freeze_c;
  assign ex_bubble   = ex_bubble_c;
  assign if_flush    = if_flush_c;
  assign late_freeze = late_freeze_c;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_hazard_controller.sv
// Scoreboard bench for id_hazard_controller across three parameter sets:
// dut 0 FORWARD_EN=0/WB_HAZARD=1, dut 1 FORWARD_EN=1, dut 2 FORWARD_EN=0/WB_HAZARD=0.
module tb_id_hazard_controller;

  // Control vector order: {if_freeze, id_freeze, ex_bubble, if_flush, late_freeze}
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_STALL = 5'b11100;
  localparam logic [4:0] C_FLUSH = 5'b00110;
  localparam logic [4:0] C_BUSY  = 5'b11001;

  typedef struct {
    int          d;
    logic [4:0]  ctl;
    logic [15:0] cnt;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a  [3];
  logic        v_a    [3];
  logic [4:0]  s1_a   [3];
  logic [4:0]  s2_a   [3];
  logic        u2_a   [3];
  logic        wb_a   [3];
  logic [4:0]  dst_a  [3];
  logic        mr_a   [3];
  logic        br_a   [3];
  logic        busy_a [3];
  logic        if_fz  [3];
  logic        id_fz  [3];
  logic        ex_bub [3];
  logic        if_fl  [3];
  logic        late_fz[3];
  logic [15:0] cnt_a  [3];

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  id_hazard_controller #(.FORWARD_EN(1'b0), .WB_HAZARD(1'b1)) dut0 (
    .clk(clk), .rst(rst_a[0]), .id_valid(v_a[0]), .id_src1(s1_a[0]), .id_src2(s2_a[0]),
    .id_uses_src2(u2_a[0]), .id_wb_en(wb_a[0]), .id_dest(dst_a[0]), .id_mem_read(mr_a[0]),
    .br_taken(br_a[0]), .mem_busy(busy_a[0]), .if_freeze(if_fz[0]), .id_freeze(id_fz[0]),
    .ex_bubble(ex_bub[0]), .if_flush(if_fl[0]), .late_freeze(late_fz[0]), .stall_cnt(cnt_a[0]));

  id_hazard_controller #(.FORWARD_EN(1'b1), .WB_HAZARD(1'b1)) dut1 (
    .clk(clk), .rst(rst_a[1]), .id_valid(v_a[1]), .id_src1(s1_a[1]), .id_src2(s2_a[1]),
    .id_uses_src2(u2_a[1]), .id_wb_en(wb_a[1]), .id_dest(dst_a[1]), .id_mem_read(mr_a[1]),
    .br_taken(br_a[1]), .mem_busy(busy_a[1]), .if_freeze(if_fz[1]), .id_freeze(id_fz[1]),
    .ex_bubble(ex_bub[1]), .if_flush(if_fl[1]), .late_freeze(late_fz[1]), .stall_cnt(cnt_a[1]));

  id_hazard_controller #(.FORWARD_EN(1'b0), .WB_HAZARD(1'b0)) dut2 (
    .clk(clk), .rst(rst_a[2]), .id_valid(v_a[2]), .id_src1(s1_a[2]), .id_src2(s2_a[2]),
    .id_uses_src2(u2_a[2]), .id_wb_en(wb_a[2]), .id_dest(dst_a[2]), .id_mem_read(mr_a[2]),
    .br_taken(br_a[2]), .mem_busy(busy_a[2]), .if_freeze(if_fz[2]), .id_freeze(id_fz[2]),
    .ex_bubble(ex_bub[2]), .if_flush(if_fl[2]), .late_freeze(late_fz[2]), .stall_cnt(cnt_a[2]));

  // Park every DUT on idle inputs with reset released.
  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      rst_a[i] = 1'b1; v_a[i] = 1'b0; s1_a[i] = 5'd0; s2_a[i] = 5'd0; u2_a[i] = 1'b0;
      wb_a[i] = 1'b0; dst_a[i] = 5'd0; mr_a[i] = 1'b0; br_a[i] = 1'b0; busy_a[i] = 1'b0;
    end
  endtask

  // Drive one cycle into DUT d and queue the expected response for that cycle.
  task automatic cyc(input int d, input bit r, input bit v, input logic [4:0] s1,
                     input logic [4:0] s2, input bit u2, input bit wb, input logic [4:0] dst,
                     input bit mr, input bit br, input bit busy,
                     input logic [4:0] ctl, input logic [15:0] cnt, input string nm);
    exp_t e;
    @(posedge clk); #1;
    idle_all();
    rst_a[d] = r; v_a[d] = v; s1_a[d] = s1; s2_a[d] = s2; u2_a[d] = u2;
    wb_a[d] = wb; dst_a[d] = dst; mr_a[d] = mr; br_a[d] = br; busy_a[d] = busy;
    e.d = d; e.ctl = ctl; e.cnt = cnt; e.nm = nm;
    sb.push_back(e);
  endtask

  // Monitor: every cycle that has an expectation, compare mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [4:0] act;
      e = sb.pop_front();
      act = {if_fz[e.d], id_fz[e.d], ex_bub[e.d], if_fl[e.d], late_fz[e.d]};
      checks++;
      if (act !== e.ctl) begin
        failures++;
        $display("FAIL %s dut%0d ctl actual=%b expected=%b", e.nm, e.d, act, e.ctl);
      end
      checks++;
      if (cnt_a[e.d] !== e.cnt) begin
        failures++;
        $display("FAIL %s dut%0d stall_cnt actual=%0d expected=%0d", e.nm, e.d, cnt_a[e.d], e.cnt);
      end
    end
  end

  initial begin
    idle_all();
    for (int i = 0; i < 3; i++) rst_a[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle_all();

    // d  r  v  s1 s2 u2 wb dst mr br bz  ctl      cnt
    // Back-to-back RAW, no forwarding, WB hazard on: three stalls.
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  0, "reset_state");
    cyc(0, 1, 1, 1, 2, 1, 1, 3, 0, 0, 0, C_NONE,  0, "add_r3");
    cyc(0, 1, 1, 3, 4, 1, 1, 6, 0, 0, 0, C_STALL, 0, "raw_ex");
    cyc(0, 1, 1, 3, 4, 1, 1, 6, 0, 0, 0, C_STALL, 1, "raw_mem");
    cyc(0, 1, 1, 3, 4, 1, 1, 6, 0, 0, 0, C_STALL, 2, "raw_wb");
    cyc(0, 1, 1, 3, 4, 1, 1, 6, 0, 0, 0, C_NONE,  3, "raw_release");
    cyc(0, 1, 0, 6, 0, 0, 0, 0, 0, 0, 0, C_NONE,  3, "id_invalid");
    // Register zero never stalls.
    cyc(0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, C_NONE,  3, "r0_producer");
    cyc(0, 1, 1, 0, 9, 1, 0, 0, 0, 0, 0, C_NONE,  3, "r0_consumer");

    // Forwarding: load-use stalls once, src2 ignored when unused, ALU result forwards.
    cyc(1, 1, 1, 1, 2, 0, 1, 5, 1, 0, 0, C_NONE,  0, "fw_ld_r5");
    cyc(1, 1, 1, 7, 5, 1, 1, 8, 0, 0, 0, C_STALL, 0, "fw_load_use");
    cyc(1, 1, 1, 7, 5, 1, 1, 8, 0, 0, 0, C_NONE,  1, "fw_load_use_done");
    cyc(1, 0, 1, 7, 5, 1, 1, 8, 0, 0, 0, C_NONE,  1, "fw_reset");
    cyc(1, 1, 1, 1, 2, 0, 1, 5, 1, 0, 0, C_NONE,  0, "fw_ld_r5_b");
    cyc(1, 1, 1, 7, 5, 0, 1, 8, 0, 0, 0, C_NONE,  0, "fw_src2_unused");
    cyc(1, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, C_NONE,  0, "fw_alu_forward");

    // No forwarding, WB hazard off: two stalls.
    cyc(2, 1, 1, 0, 0, 0, 1, 4, 0, 0, 0, C_NONE,  0, "nowb_producer");
    cyc(2, 1, 1, 9, 4, 1, 0, 0, 0, 0, 0, C_STALL, 0, "nowb_ex");
    cyc(2, 1, 1, 9, 4, 1, 0, 0, 0, 0, 0, C_STALL, 1, "nowb_mem");
    cyc(2, 1, 1, 9, 4, 1, 0, 0, 0, 0, 0, C_NONE,  2, "nowb_wb_free");

    // Branch taken together with a hazard: flush wins, squashed op untracked.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  3, "br_reset");
    cyc(0, 1, 1, 0, 0, 0, 1, 3, 0, 0, 0, C_NONE,  0, "br_producer");
    cyc(0, 1, 1, 3, 0, 0, 1, 7, 0, 1, 0, C_FLUSH, 0, "br_flush_hazard");
    cyc(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, C_NONE,  0, "br_ex_invalid");
    cyc(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, C_STALL, 0, "br_wb_match");
    cyc(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, C_NONE,  1, "br_release");

    // Memory busy for four cycles mid-hazard; branch during busy is ignored.
    cyc(0, 1, 1, 0, 0, 0, 1, 10, 0, 0, 0, C_NONE,  1, "busy_producer");
    cyc(0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0, C_STALL, 1, "busy_stall1");
    cyc(0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 1, C_BUSY,  2, "busy_c1");
    cyc(0, 1, 1, 10, 0, 0, 0, 0, 0, 1, 1, C_BUSY,  2, "busy_c2_br");
    cyc(0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 1, C_BUSY,  2, "busy_c3");
    cyc(0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 1, C_BUSY,  2, "busy_c4");
    cyc(0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0, C_STALL, 2, "busy_resume_mem");
    cyc(0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0, C_STALL, 3, "busy_resume_wb");
    cyc(0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0, C_NONE,  4, "busy_done");

    // Reset during the second stall cycle.
    cyc(0, 1, 1, 0, 0, 0, 1, 12, 0, 0, 0, C_NONE,  4, "rs_producer");
    cyc(0, 1, 1, 12, 0, 0, 0, 0, 0, 0, 0, C_STALL, 4, "rs_stall1");
    cyc(0, 0, 1, 12, 0, 0, 0, 0, 0, 1, 1, C_NONE,  5, "rs_reset_low");
    cyc(0, 1, 1, 12, 0, 0, 0, 0, 0, 0, 0, C_NONE,  0, "rs_after_release");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE,  0, "rs_idle");

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_hazard_controller.md
# id_hazard_controller

Pipeline sequencing controller for the five-stage core. It sits beside the decode stage, keeps a registered shadow scoreboard of the instructions in EX, MEM and WB, and detects read-after-write hazards against the instruction currently in ID. It also applies branch flushes resolved in EX and freezes the pipeline while the memory stage reports busy. It drives the freeze, flush and bubble controls of the IF/ID, ID/EX and later pipeline registers.

## Interface
Parameters:
- FORWARD_EN, default 0: 1 means a forwarding unit exists, so only load-use hazards (EX entry is a load) stall.
- WB_HAZARD, default 1: 1 means a match against the WB entry also stalls (register file not write-before-read). Ignored when FORWARD_EN=1.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_src1  in  5  Instruction[25:21] of ID instruction
- id_src2  in  5  Instruction[20:16] of ID instruction
- id_uses_src2  in  1  ID instruction reads src2 (R-type, store, branch); 0 for immediate ops
- id_wb_en  in  1  ID instruction writes the register file
- id_dest  in  5  destination selected in ID
- id_mem_read  in  1  ID instruction is a load
- br_taken  in  1  branch in EX resolved taken
- mem_busy  in  1  memory stage not ready; pipeline must hold
- if_freeze  out  1  hold PC and IF/ID
- id_freeze  out  1  hold ID inputs (same value as if_freeze)
- ex_bubble  out  1  load a NOP into ID/EX (wb/mem controls cleared)
- if_flush  out  1  clear IF/ID to NOP
- late_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- stall_cnt  out  16  saturating count of hazard-stall cycles

## Operation
- Scoreboard: three registered entries EX, MEM, WB, each {valid, wb, dest[4:0], mem_read}.
- Entry match: valid & wb & dest!=0 & (dest==id_src1 | (id_uses_src2 & dest==id_src2)).
- hazard = id_valid & (FORWARD_EN ? (EX match & EX.mem_read) : (EX match | MEM match | (WB_HAZARD & WB match))).
- Priority, evaluated each cycle: mem_busy, then br_taken, then hazard, then normal.
  - mem_busy=1: if_freeze=id_freeze=late_freeze=1; ex_bubble=0; if_flush=0; scoreboard holds; stall_cnt holds.
  - br_taken=1 (no busy): if_flush=1, ex_bubble=1, freezes 0. Scoreboard shifts and EX loads invalid, so the squashed ID instruction is never tracked.
  - hazard (no busy, no branch): if_freeze=id_freeze=1, ex_bubble=1, late_freeze=0. Scoreboard shifts, EX loads invalid, stall_cnt+1 saturating at 16'hFFFF.
  - normal: all controls 0. Scoreboard shifts: WB<=MEM, MEM<=EX, EX<={id_valid, id_wb_en, id_dest, id_mem_read}.
- Simultaneous br_taken and hazard: the flush wins, and no stall cycle is counted.
- br_taken while mem_busy: ignored that cycle. EX is frozen, so the branch is re-presented and applied on the first non-busy cycle.
- Writes to register 0 never create hazards.

## Timing
- Control outputs are combinational from the registered scoreboard plus current inputs, valid in the same cycle.
- Scoreboard and stall_cnt update on the rising clk edge only.
- Dependent instruction directly behind its producer, no other events:
  - FORWARD_EN=0, WB_HAZARD=1: 3 stall cycles.
  - FORWARD_EN=0, WB_HAZARD=0: 2 stall cycles.
  - FORWARD_EN=1 and producer is a load: 1 stall cycle.
  - FORWARD_EN=1 and producer is not a load: 0 stall cycles.
- Reset (rst=0 at a rising edge): all scoreboard entries invalid and stall_cnt=0.
  - While rst=0, all control outputs are forced to 0 regardless of inputs.
  - Reset mid-stall or mid-busy aborts the stall immediately; the first cycle after release behaves as normal with an empty scoreboard.

## Test plan
- Dependent ADD back to back: ADD r3 (dest 3), then SUB with src1=3, FORWARD_EN=0, WB_HAZARD=1 -> if_freeze=ex_bubble=1 for exactly 3 cycles, then 0; stall_cnt=3.
- Load-use with FORWARD_EN=1: LD r5, then ADD src2=5, id_uses_src2=1 -> 1 stall cycle. Same sequence with id_uses_src2=0 -> no stall.
- Register zero: producer dest=0, consumer src1=0 -> no stall, stall_cnt stays 0.
- Branch flush during hazard: hazard active and br_taken=1 in the same cycle -> if_flush=1, ex_bubble=1, if_freeze=0, stall_cnt unchanged; the next cycle's EX entry is invalid.
- Memory busy: mem_busy=1 for 4 cycles during a hazard -> all three freezes high, ex_bubble=0, scoreboard and stall_cnt frozen; the hazard countdown resumes afterward.
- Reset mid-stall: rst=0 for one edge during the second stall cycle -> outputs 0 while low, stall_cnt=0, no stall after release.
